apb_slave_mem: RTL and testbench
================================

# apb_slave_mem

Byte-addressed APB completer that sits directly downstream of the APB master and answers one slave-select line (psel1 or psel2) with a local register array. It decodes the 7-bit local offset, inserts a programmable number of wait states, and completes each transfer with pready. It flags out-of-range accesses with pslverr and returns read data aligned to the completing cycle, where the master samples prdata.

## Interface
Parameters:
- DEPTH, 64: number of 8-bit locations. Legal range 1..128.
- WAIT_CYCLES, 1: wait states inserted in each ENABLE phase. Legal range 0..15.

Ports:
- pclk  input  1  APB clock. Every register updates on the rising edge.
- preset  input  1  Reset. Synchronous and active-high.
- psel  input  1  Select for this slave. Wired to psel1 or psel2.
- penable  input  1  ENABLE-phase indicator.
- pwrite  input  1  1 = write, 0 = read.
- paddr  input  8  Address. Only paddr[6:0] is decoded; bit 7 is the slave select and is already resolved upstream.
- pwdata  input  8  Write data.
- pready  output  1  Transfer complete. Registered.
- pslverr  output  1  Error response. Valid only while pready=1.
- prdata  output  8  Read data. Valid only while pready=1 and the access is a read.

## Operation
- States: IDLE, WAIT, RESP. Encoding is 2 bits.
- IDLE:
  - Setup detect (psel=1, penable=0) latches idx=paddr[6:0], wr=pwrite and wd=pwdata.
  - The same edge sets err=(idx>=DEPTH).
  - If WAIT_CYCLES=0, go to RESP. Otherwise go to WAIT with cnt=WAIT_CYCLES.
- WAIT:
  - pready=0 and cnt decrements each cycle.
  - When cnt==1, go to RESP on the next edge.
  - If psel=0 (master reset or abort), go to IDLE. No write occurs.
- RESP:
  - pready=1 and pslverr=err for exactly one cycle.
  - Write commit: at the RESP edge, if wr=1 and err=0 and psel=1, mem[idx]<=wd.
  - Next state is always IDLE.
  - A back-to-back SETUP from the master arrives in the cycle after RESP and is detected from IDLE. No dead cycle is added on the slave side.
- Read data: prdata is loaded on the edge that enters RESP.
  - Value is mem[idx], or 8'h00 if err=1.
  - prdata holds its value until the next RESP entry.
- Error accesses:
  - Write: no array update.
  - Read: prdata=8'h00.
  - Both still complete normally with pready.
- Ignored in IDLE:
  - penable=1 without a preceding setup. No response.
  - psel=0. Other inputs ignored.
- Counter: 4-bit unsigned. It never wraps, because it is loaded only with a nonzero WAIT_CYCLES and exits at 1.

## Timing
- Reset (synchronous, preset=1 at a pclk edge):
  - state=IDLE, cnt=0, pready=0, pslverr=0, prdata=8'h00.
  - All DEPTH locations cleared to 8'h00. Latched idx/wr/wd/err cleared.
- Reset mid-transfer: the transfer is abandoned and no write occurs. pready stays 0 until the next setup.
- Cycle accounting, with setup in cycle T0:
  - ENABLE occupies T1..T1+WAIT_CYCLES.
  - pready=1 in cycle T1+WAIT_CYCLES.
  - Total transfer length is 2+WAIT_CYCLES cycles.
- A written value is readable by the next transfer: the write commits at the end of RESP, and the next read's prdata load happens at least one cycle later.
- pslverr and prdata may be nonzero only while pready=1. The verifier checks them only there.

## Structure
- Shared package apb_pkg holds:
  - APB_ADDR_W=8, APB_DATA_W=8.
  - State localparams IDLE/WAIT/RESP, which the master and the slave models reuse.
  - A WAIT_CNT_W=4 constant.
- Sub-module apb_slave_regfile: synchronous-reset array with DEPTH entries of 8 bits.
  - Ports: one write port (we, waddr, wdata) and one combinational read port (raddr, rdata).
  - The top holds the FSM, the counter and the response registers.

## Test plan
- Reset:
  - Stimulus: preset=1 for 2 cycles, then read idx 0x05.
  - Required: prdata=8'h00, pslverr=0, pready=1 exactly in T2 (WAIT_CYCLES=1).
- Write then read:
  - Stimulus: write 8'hA5 to paddr 8'h10, then read 8'h10 back-to-back through the master.
  - Required: read returns 8'hA5, pslverr=0, with no idle cycle between transfers.
- Wait-state sweep:
  - Stimulus: WAIT_CYCLES=0, then 3.
  - Required: pready high in T1 and T4 respectively. penable stays high throughout ENABLE.
- Out-of-range, DEPTH=64:
  - Stimulus: write 8'h3C to paddr 8'h50 (idx 0x50, at or above DEPTH).
  - Required: pslverr=1 with pready, and a subsequent read of idx 0x10 is unchanged.
  - Stimulus: read 8'h7F.
  - Required: prdata=8'h00, pslverr=1.
- Abort:
  - Stimulus: WAIT_CYCLES=3, write 8'hFF to 8'h02, deassert psel in the second WAIT cycle.
  - Required: FSM returns to IDLE, pready never asserts, and a later read of 8'h02 returns the prior value.
- Stray penable:
  - Stimulus: penable=1, psel=1 in IDLE without a setup cycle.
  - Required: pready stays 0 and no state change.

Source files
------------

// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared APB widths, FSM state encoding and wait-counter width
package apb_pkg;

  localparam int APB_ADDR_W = 8;
  localparam int APB_DATA_W = 8;
  localparam int WAIT_CNT_W = 4;

  // Transfer phases as seen by a completer; reused by master and slave models.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } apb_state_e;

endpackage

// File: rtl/apb_slave_mem_if.sv
// rtl/apb_slave_mem_if.sv - APB request/response signal bundle with master and slave views
interface apb_slave_mem_if;
  import apb_pkg::*;

  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [APB_ADDR_W-1:0] paddr;
  logic [APB_DATA_W-1:0] pwdata;
  logic                  pready;
  logic                  pslverr;
  logic [APB_DATA_W-1:0] prdata;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  pready, pslverr, prdata
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output pready, pslverr, prdata
  );

endinterface

// File: rtl/apb_slave_regfile.sv
// rtl/apb_slave_regfile.sv - byte array with one synchronous write port and one combinational read port
module apb_slave_regfile
  import apb_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [APB_DATA_W-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [APB_DATA_W-1:0] rdata
);

  logic [APB_DATA_W-1:0] mem [DEPTH];

  // Clear every location on reset, otherwise commit a single write per cycle.
  always_ff @(posedge pclk) begin
    if (preset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/apb_slave_mem.sv
// rtl/apb_slave_mem.sv - APB completer with programmable wait states backed by a local byte array
module apb_slave_mem
  import apb_pkg::*;
#(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 1
) (
  input  logic          pclk,
  input  logic          preset,
  apb_slave_mem_if.slave bus
);

  // Array index width; at least one bit so tiny arrays still have an address.
  localparam int AW = (DEPTH <= 2) ? 1 : $clog2(DEPTH);
  localparam logic [7:0]            DEPTH_W = 8'(DEPTH);
  localparam logic [WAIT_CNT_W-1:0] WAIT_LD = WAIT_CNT_W'(WAIT_CYCLES);

  apb_state_e            state, next_state;
  logic [WAIT_CNT_W-1:0] cnt;
  logic [6:0]            idx;
  logic                  wr;
  logic [APB_DATA_W-1:0] wd;
  logic                  err;
  logic                  pready_q;
  logic                  pslverr_q;
  logic [APB_DATA_W-1:0] prdata_q;

  logic                  setup;
  logic                  setup_err;
  logic [6:0]            rd_idx;
  logic                  rd_err;
  logic                  enter_resp;
  logic                  rf_we;
  logic [APB_DATA_W-1:0] rf_rdata;

  // paddr[7] is the slave select, already decoded by the interconnect.
  logic unused_addr_msb;
  assign unused_addr_msb = bus.paddr[7];

  assign setup      = bus.psel && !bus.penable;
  assign setup_err  = ({1'b0, bus.paddr[6:0]} >= DEPTH_W);

  // With no wait states RESP is entered on the setup edge, before idx/err are latched,
  // so the read path looks through to the live address in IDLE.
  assign rd_idx     = (state == IDLE) ? bus.paddr[6:0] : idx;
  assign rd_err     = (state == IDLE) ? setup_err : err;
  assign enter_resp = (next_state == RESP);
  assign rf_we      = (state == RESP) && wr && !err && bus.psel;

  // State register.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode: setup starts a transfer, psel loss aborts it, RESP lasts one cycle.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (setup) begin
          next_state = (WAIT_CYCLES == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (!bus.psel) begin
          next_state = IDLE;
        end else if (cnt == WAIT_CNT_W'(1)) begin
          next_state = RESP;
        end
      end
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Capture the request at setup and count down the wait states.
  always_ff @(posedge pclk) begin
    if (preset) begin
      cnt <= '0;
      idx <= '0;
      wr  <= 1'b0;
      wd  <= '0;
      err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (setup) begin
            idx <= bus.paddr[6:0];
            wr  <= bus.pwrite;
            wd  <= bus.pwdata;
            err <= setup_err;
            cnt <= (WAIT_CYCLES == 0) ? '0 : WAIT_LD;
          end
        end
        WAIT:    cnt <= bus.psel ? (cnt - WAIT_CNT_W'(1)) : '0;
        default: ;
      endcase
    end
  end

  // Response registers: pready/pslverr pulse for the RESP cycle, prdata holds until the next one.
  always_ff @(posedge pclk) begin
    if (preset) begin
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      pready_q  <= enter_resp;
      pslverr_q <= enter_resp && rd_err;
      if (enter_resp) begin
        prdata_q <= rd_err ? '0 : rf_rdata;
      end
    end
  end

  apb_slave_regfile #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_regfile (
    .pclk   (pclk),
    .preset (preset),
    .we     (rf_we),
    .waddr  (idx[AW-1:0]),
    .wdata  (wd),
    .raddr  (rd_idx[AW-1:0]),
    .rdata  (rf_rdata)
  );

  assign bus.pready  = pready_q;
  assign bus.pslverr = pslverr_q;
  assign bus.prdata  = prdata_q;

endmodule

// File: tb/tb_apb_slave_mem.sv
// tb/tb_apb_slave_mem.sv - scoreboard bench over three completers with 1, 0 and 3 wait states
module tb_apb_slave_mem;

  typedef struct {
    int         inst;
    logic       rd;
    logic       err;
    logic [7:0] rdata;
    int         lat;
  } exp_t;

  logic       pclk = 1'b0;
  logic       preset;
  logic       psel_v    [3];
  logic       penable_v [3];
  logic       pwrite_v  [3];
  logic [7:0] paddr_v   [3];
  logic [7:0] pwdata_v  [3];
  logic       pready_o  [3];
  logic       pslverr_o [3];
  logic [7:0] prdata_o  [3];

  logic [7:0] model [3][128];
  exp_t       sb [$];
  int         n_tests = 0;
  int         n_fail  = 0;

  always #5 pclk = ~pclk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int WC = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
    apb_slave_mem_if bus();
    assign bus.psel    = psel_v[g];
    assign bus.penable = penable_v[g];
    assign bus.pwrite  = pwrite_v[g];
    assign bus.paddr   = paddr_v[g];
    assign bus.pwdata  = pwdata_v[g];
    assign pready_o[g]  = bus.pready;
    assign pslverr_o[g] = bus.pslverr;
    assign prdata_o[g]  = bus.prdata;
    apb_slave_mem #(.DEPTH(64), .WAIT_CYCLES(WC)) u_dut (
      .pclk   (pclk),
      .preset (preset),
      .bus    (bus.slave)
    );
  end

  function automatic int wc(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 0 : 3);
  endfunction

  // One full transfer, entered just after a rising edge; returns just after its RESP edge.
  task automatic xfer(input int d, input logic wr, input logic [7:0] addr, input logic [7:0] wdata);
    exp_t e;
    exp_t got_e;
    int   cyc;
    logic got;
    e.inst  = d;
    e.rd    = !wr;
    e.err   = (addr[6:0] >= 7'd64);
    e.rdata = e.err ? 8'h00 : model[d][addr[6:0]];
    e.lat   = 1 + wc(d);
    sb.push_back(e);
    if (wr && !e.err) model[d][addr[6:0]] = wdata;
    #1;
    psel_v[d] = 1'b1; penable_v[d] = 1'b0; pwrite_v[d] = wr;
    paddr_v[d] = addr; pwdata_v[d] = wdata;
    @(negedge pclk);
    n_tests++;
    if (pready_o[d] !== 1'b0) begin
      $display("FAIL setup_pready inst=%0d addr=%h got=%b exp=0", d, addr, pready_o[d]);
      n_fail++;
    end
    @(posedge pclk);
    #1 penable_v[d] = 1'b1;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 40) begin
      @(negedge pclk);
      cyc++;
      if (pready_o[d] === 1'b1) got = 1'b1;
      else @(posedge pclk);
    end
    got_e = sb.pop_front();
    n_tests++;
    if (!got) begin
      $display("FAIL timeout inst=%0d addr=%h got=no_pready exp=pready_within_40", d, addr);
      n_fail++;
    end else begin
      if (cyc !== got_e.lat) begin
        $display("FAIL latency inst=%0d addr=%h got=%0d exp=%0d", d, addr, cyc, got_e.lat);
        n_fail++;
      end
      n_tests++;
      if (pslverr_o[d] !== got_e.err) begin
        $display("FAIL pslverr inst=%0d addr=%h got=%b exp=%b", d, addr, pslverr_o[d], got_e.err);
        n_fail++;
      end
      if (got_e.rd) begin
        n_tests++;
        if (prdata_o[d] !== got_e.rdata) begin
          $display("FAIL prdata inst=%0d addr=%h got=%h exp=%h", d, addr, prdata_o[d], got_e.rdata);
          n_fail++;
        end
      end
    end
    @(posedge pclk);
  endtask

  task automatic idle_all();
    #1;
    for (int d = 0; d < 3; d++) begin
      psel_v[d] = 1'b0; penable_v[d] = 1'b0;
    end
    @(posedge pclk);
  endtask

  task automatic test_reset();
    preset = 1'b1;
    for (int d = 0; d < 3; d++) begin
      psel_v[d] = 1'b0; penable_v[d] = 1'b0; pwrite_v[d] = 1'b0;
      paddr_v[d] = 8'h00; pwdata_v[d] = 8'h00;
      for (int i = 0; i < 128; i++) model[d][i] = 8'h00;
    end
    repeat (2) @(posedge pclk);
    @(negedge pclk);
    for (int d = 0; d < 3; d++) begin
      n_tests++;
      if (pready_o[d] !== 1'b0 || pslverr_o[d] !== 1'b0 || prdata_o[d] !== 8'h00) begin
        $display("FAIL reset_outputs inst=%0d got=%b/%b/%h exp=0/0/00", d, pready_o[d], pslverr_o[d], prdata_o[d]);
        n_fail++;
      end
    end
    preset = 1'b0;
    @(posedge pclk);
    xfer(0, 1'b0, 8'h05, 8'h00);
    xfer(2, 1'b0, 8'h3F, 8'h00);
    idle_all();
  endtask

  task automatic test_write_read();
    xfer(0, 1'b1, 8'h10, 8'hA5);
    xfer(0, 1'b0, 8'h10, 8'h00);
    xfer(0, 1'b1, 8'h00, 8'h5C);
    xfer(0, 1'b0, 8'h00, 8'h00);
    xfer(0, 1'b0, 8'h90, 8'h00);
    idle_all();
  endtask

  task automatic test_wait_sweep();
    xfer(1, 1'b1, 8'h3F, 8'h5A);
    xfer(1, 1'b0, 8'h3F, 8'h00);
    xfer(1, 1'b0, 8'h7F, 8'h00);
    xfer(2, 1'b1, 8'h20, 8'hC3);
    xfer(2, 1'b0, 8'h20, 8'h00);
    idle_all();
  endtask

  task automatic test_out_of_range();
    xfer(0, 1'b1, 8'h50, 8'h3C);
    xfer(0, 1'b0, 8'h10, 8'h00);
    xfer(0, 1'b0, 8'h7F, 8'h00);
    xfer(0, 1'b0, 8'h40, 8'h00);
    xfer(0, 1'b0, 8'h3F, 8'h00);
    idle_all();
  endtask

  task automatic test_abort();
    logic saw;
    xfer(2, 1'b1, 8'h02, 8'h11);
    #1;
    psel_v[2] = 1'b1; penable_v[2] = 1'b0; pwrite_v[2] = 1'b1;
    paddr_v[2] = 8'h02; pwdata_v[2] = 8'hFF;
    @(posedge pclk);
    #1 penable_v[2] = 1'b1;
    saw = 1'b0;
    @(negedge pclk);
    if (pready_o[2] !== 1'b0) saw = 1'b1;
    @(posedge pclk);
    #1 psel_v[2] = 1'b0; penable_v[2] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge pclk);
      if (pready_o[2] !== 1'b0) saw = 1'b1;
    end
    n_tests++;
    if (saw) begin
      $display("FAIL abort_pready inst=2 got=asserted exp=never");
      n_fail++;
    end
    @(posedge pclk);
    xfer(2, 1'b0, 8'h02, 8'h00);
    idle_all();
  endtask

  task automatic test_stray_penable();
    logic saw;
    #1;
    psel_v[0] = 1'b1; penable_v[0] = 1'b1; pwrite_v[0] = 1'b1;
    paddr_v[0] = 8'h10; pwdata_v[0] = 8'hEE;
    saw = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge pclk);
      if (pready_o[0] !== 1'b0) saw = 1'b1;
    end
    n_tests++;
    if (saw) begin
      $display("FAIL stray_penable inst=0 got=pready exp=no_response");
      n_fail++;
    end
    @(posedge pclk);
    xfer(0, 1'b0, 8'h10, 8'h00);
    idle_all();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_wait_sweep();
    test_out_of_range();
    test_abort();
    test_stray_penable();
    n_tests++;
    if (sb.size() != 0) begin
      $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size());
      n_fail++;
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
